// File: rtl/pixel_clip_queue.sv
// rtl/pixel_clip_queue.sv - clip signed candidate pixels to the frame and queue them for the VGA plot port
module pixel_clip_queue #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_x,
    input  logic [7:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        out_en,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        empty,
    output logic [15:0] clipped_count,
    output logic [15:0] plotted_count
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [8:0]     X_LIM   = 9'(SCREEN_W);
    localparam logic [7:0]     Y_LIM   = 8'(SCREEN_H);
    localparam logic [15:0]    CNT_MAX = 16'hFFFF;

    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          in_pass;
    logic          accept;
    logic          push;
    logic          pop;
    logic          clip;

    // Sign bit clear means non-negative, so the upper bound can be an unsigned compare.
    assign in_pass  = !in_x[8] && (in_x < X_LIM) && !in_y[7] && (in_y < Y_LIM);
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign accept   = in_valid && in_ready && !clear;
    assign push     = accept && in_pass;
    assign clip     = accept && !in_pass;
    // Pop looks at occupancy before this edge's push, so no same-cycle bypass.
    assign pop      = !empty && out_en && !clear;

    // Storage array: written only on a passing push, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_x[7:0], in_y[6:0], in_colour};
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Output register: load the head entry on pop; coordinates hold otherwise and through clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (clear) begin
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= pop;
            if (pop) begin
                {vga_x, vga_y, vga_colour} <= mem[rd_ptr];
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clipped_count <= '0;
            plotted_count <= '0;
        end else if (clear) begin
            clipped_count <= '0;
            plotted_count <= '0;
        end else begin
            if (clip && clipped_count != CNT_MAX)     clipped_count <= clipped_count + 1'b1;
            if (vga_plot && plotted_count != CNT_MAX) plotted_count <= plotted_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_clip_queue.sv
// tb/tb_pixel_clip_queue.sv - scoreboard bench for pixel_clip_queue
module tb_pixel_clip_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [2:0]  in_colour = '0;
    logic        out_en = 1'b0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        empty;
    logic [15:0] clipped_count;
    logic [15:0] plotted_count;

    pixel_clip_queue #(.DEPTH(8), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .out_en(out_en),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .empty(empty), .clipped_count(clipped_count), .plotted_count(plotted_count)
    );

    always #5 clk = ~clk;

    int          nchk = 0;
    int          nfail = 0;
    int          edge_cnt = 0;
    int          mcount = 0;
    int          mclip = 0;
    int          mplot = 0;
    logic [17:0] exp_q[$];
    int          strobe_edges[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected pixel.
    always @(negedge clk) begin
        if (rst_n && vga_plot) begin
            nchk++;
            strobe_edges.push_back(edge_cnt);
            mplot++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_strobe: got x=%0d y=%0d c=%0d expected none", vga_x, vga_y, vga_colour);
            end else begin
                if ({vga_x, vga_y, vga_colour} != exp_q[0]) begin
                    nfail++;
                    $display("FAIL pixel: got %h expected %h", {vga_x, vga_y, vga_colour}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    // One clock cycle of stimulus; the reference model advances at the rising edge.
    task automatic do_cycle(input bit v, input int x, input int y, input bit [2:0] c,
                            input bit oe, input bit clr, output bit hs);
        bit pass;
        bit pop;
        logic [8:0] xv;
        logic [7:0] yv;
        xv = x[8:0];
        yv = y[7:0];
        in_valid = v; in_x = xv; in_y = yv; in_colour = c; out_en = oe; clear = clr;
        @(negedge clk);
        check("in_ready", int'(in_ready), int'(mcount < 8));
        check("empty", int'(empty), int'(mcount == 0));
        hs = v && in_ready;
        pass = (x >= 0) && (x < 160) && (y >= 0) && (y < 120);
        @(posedge clk);
        if (clr) begin
            exp_q.delete();
            mcount = 0;
            mclip = 0;
            mplot = 0;
        end else begin
            pop = (mcount > 0) && oe;
            if (hs && pass) exp_q.push_back({xv[7:0], yv[6:0], c});
            else if (hs) mclip++;
            mcount += int'(hs && pass) - int'(pop);
        end
        #2;
        in_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic idle(input bit oe, input int n);
        bit hs;
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 3'd0, oe, 0, hs);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            idle(1, 1);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        idle(1, 2);
    endtask

    initial begin
        bit hs;
        int acc;
        int acc_edge;
        int x;
        int y;

        // Reset values while held in reset
        #1;
        check("rst_plot", int'(vga_plot), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_ready", int'(in_ready), 1);
        check("rst_xyc", int'({vga_x, vga_y, vga_colour}), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single pixel latency
        strobe_edges.delete();
        do_cycle(1, 10, 20, 3'b101, 1, 0, hs);
        acc_edge = edge_cnt;
        check("single_hs", int'(hs), 1);
        drain();
        check("single_strobes", strobe_edges.size(), 1);
        if (strobe_edges.size() > 0) check("single_latency", strobe_edges[0] - acc_edge, 1);
        check("single_x", int'(vga_x), 10);
        check("single_y", int'(vga_y), 20);
        check("single_c", int'(vga_colour), 5);
        check("single_plotted", int'(plotted_count), 1);

        // Clipping
        do_cycle(0, 0, 0, 3'd0, 0, 1, hs);
        do_cycle(1, -1, 5, 3'd1, 1, 0, hs);
        do_cycle(1, 160, 5, 3'd2, 1, 0, hs);
        do_cycle(1, 5, 120, 3'd3, 1, 0, hs);
        do_cycle(1, 159, 119, 3'd4, 1, 0, hs);
        do_cycle(1, 0, 0, 3'd6, 1, 0, hs);
        drain();
        check("clip_clipped", int'(clipped_count), 3);
        check("clip_plotted", int'(plotted_count), 2);

        // Full and backpressure
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            do_cycle(1, i * 3, i * 2, 3'(i), 0, 0, hs);
            if (hs) acc++;
        end
        check("full_accepts", acc, 8);
        check("full_ready_low", int'(in_ready), 0);
        strobe_edges.delete();
        drain();
        check("full_strobes", strobe_edges.size(), 8);
        for (int i = 1; i < strobe_edges.size(); i++)
            check("full_consecutive", strobe_edges[i] - strobe_edges[i-1], 1);

        // Stream 40 in-range pixels with out_en toggling
        acc = 0;
        for (int i = 0; i < 600 && acc < 40; i++) begin
            do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 159), $urandom_range(0, 119),
                     3'($urandom), $urandom_range(0, 1) == 1, 0, hs);
            if (hs) acc++;
        end
        check("stream_accepts", acc, 40);
        drain();

        // Random mix including off-screen candidates
        do_cycle(0, 0, 0, 3'd0, 0, 1, hs);
        for (int i = 0; i < 300; i++) begin
            x = int'($urandom_range(0, 200)) - 20;
            y = int'($urandom_range(0, 137)) - 10;
            do_cycle($urandom_range(0, 3) != 0, x, y, 3'($urandom), $urandom_range(0, 2) != 0, 0, hs);
        end
        drain();
        check("rand_clipped", int'(clipped_count), mclip);
        check("rand_plotted", int'(plotted_count), mplot);

        // Clear with five queued entries and a simultaneous push
        for (int i = 0; i < 5; i++) do_cycle(1, 50 + i, 60, 3'd2, 0, 0, hs);
        do_cycle(1, 7, 7, 3'd7, 0, 1, hs);
        #1;
        check("clear_empty", int'(empty), 1);
        check("clear_clipped", int'(clipped_count), 0);
        check("clear_plotted", int'(plotted_count), 0);
        idle(1, 5);
        check("clear_no_strobe", int'(plotted_count), 0);

        // Reset mid-burst
        for (int i = 0; i < 4; i++) do_cycle(1, 30 + i, 40, 3'd1, 0, 0, hs);
        do_cycle(0, 0, 0, 3'd0, 1, 0, hs);
        rst_n = 1'b0;
        exp_q.delete();
        mcount = 0;
        #1;
        check("mid_rst_plot", int'(vga_plot), 0);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_xyc", int'({vga_x, vga_y, vga_colour}), 0);
        check("mid_rst_cnt", int'(plotted_count) + int'(clipped_count), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        mplot = 0;
        idle(1, 6);
        check("post_rst_plotted", int'(plotted_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/pixel_clip_queue.md
# pixel_clip_queue

Buffering and clipping stage between the shape-drawing engines (circle / Reuleaux triangle) and the VGA adapter's plot port. Drawing engines emit signed candidate pixels that may fall off-screen. This block:
- discards pixels outside the 160×120 frame;
- queues the rest in a small FIFO;
- replays them to the adapter one per cycle while `out_en` is high, so the engine never stalls on adapter-side gating.

## Interface

Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `SCREEN_W`, 160: x is valid when 0 ≤ x < `SCREEN_W`.
- `SCREEN_H`, 120: y is valid when 0 ≤ y < `SCREEN_H`.

Ports:
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush of FIFO and counters.
- `in_valid` in 1: candidate pixel present.
- `in_ready` out 1: block can accept a candidate this cycle.
- `in_x` in 9: signed two's-complement x.
- `in_y` in 8: signed two's-complement y.
- `in_colour` in 3: pixel colour.
- `out_en` in 1: adapter may be written this cycle.
- `vga_x` out 8: registered x to adapter.
- `vga_y` out 7: registered y to adapter.
- `vga_colour` out 3: registered colour.
- `vga_plot` out 1: one-cycle write strobe.
- `empty` out 1: FIFO holds no entries.
- `clipped_count` out 16: candidates discarded since reset/clear.
- `plotted_count` out 16: strobes issued since reset/clear.

## Operation

- **Accept.** A handshake completes when `in_valid && in_ready`.
  - `in_ready = !full`, combinational from the occupancy count only; there is no same-cycle bypass when full.
- **Clip test** on accepted candidates:
  - x must be non-negative and `< SCREEN_W`; y must be non-negative and `< SCREEN_H`; both comparisons are signed.
  - A pass enqueues {x[7:0], y[6:0], colour}.
  - A fail enqueues nothing and increments `clipped_count`.
- **FIFO.** Circular buffer with read/write pointers and an occupancy count 0..`DEPTH`.
  - `full` means count == `DEPTH`; `empty` means count == 0.
  - Pointers wrap modulo `DEPTH`.
- **Pop.** Occurs when `!empty && out_en`.
  - The head entry is registered into `vga_x`/`vga_y`/`vga_colour`; `vga_plot` = 1 on the next cycle.
  - Otherwise `vga_plot` = 0, and `vga_x`/`vga_y`/`vga_colour` hold their last values.
- **Simultaneous push and pop.** Both take effect and the count is unchanged. A push into an empty FIFO cannot pop in the same cycle.
- **Counters.**
  - `plotted_count` increments each cycle `vga_plot` is 1.
  - Both counters saturate at 16'hFFFF; they do not wrap.
- **`clear`** has priority over push and pop in the same cycle:
  - count and pointers go to 0; both counters go to 0; `vga_plot` goes to 0;
  - `vga_x`/`vga_y`/`vga_colour` hold their values;
  - a handshake occurring in that cycle is dropped and not counted.
- **Reset values** (`rst_n` low, immediately and asynchronously):
  - `vga_x`=0, `vga_y`=0, `vga_colour`=0, `vga_plot`=0;
  - `empty`=1, `in_ready`=1;
  - both counters 0; pointers 0.
- **Reset mid-stream.** All queued pixels are lost. No strobe is issued after `rst_n` falls.

## Timing

- **Latency, empty FIFO with `out_en`=1.** A candidate accepted at edge N is popped at edge N+1; `vga_plot`=1 for the cycle following edge N+1 (2 edges total).
- **Throughput.** One pixel per cycle sustained when `out_en` is held high.
- **Full assertion.** `in_ready` falls in the cycle after the edge that makes count == `DEPTH`. It rises in the cycle after the first pop from full.
- **Clipped candidates** consume one handshake cycle and produce no strobe. `clipped_count` updates at the accepting edge.
- **`out_en` deassertion.** Takes effect on the same edge: no pop, and `vga_plot` is 0 in the following cycle.
- **Outputs.** All outputs except `in_ready` are registered.

## Test plan

- **Reset.** Hold `rst_n`=0 mid-burst.
  - Required: all outputs at reset values asynchronously, before the next edge.
  - After release: `empty`=1, `in_ready`=1, no strobes.
- **Single pixel.** Push (10, 20, 3'b101) with `out_en`=1.
  - Required: `vga_plot`=1 exactly one cycle, two edges after acceptance, with `vga_x`=10, `vga_y`=20, `vga_colour`=5; `plotted_count`=1.
- **Clipping.** Push (-1, 5), (160, 5), (5, 120), (159, 119), (0, 0).
  - Required: only the last two plotted, in order; `clipped_count`=3; `plotted_count`=2.
- **Full / backpressure.** `out_en`=0, push 10 pixels with `DEPTH`=8.
  - Required: `in_ready` drops after 8 accepts.
  - Then `out_en`=1: 8 strobes on consecutive cycles in FIFO order, and `in_ready` returns after the first pop.
- **Wrap and simultaneous push/pop.** Stream 40 in-range pixels with `out_en` toggling pseudo-randomly.
  - Required: output sequence identical to input order; occupancy never exceeds 8.
- **Clear.** With 5 entries queued and counters nonzero, pulse `clear` in the same cycle as a valid push.
  - Required: `empty`=1 next cycle, counters 0, no further strobes, pushed pixel dropped.
